// File: rtl/fpgart_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
// The timeout feature in ps2_host_tx is enabled by defining PS2_TX_TIMEOUT_EN.
package fpgart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Default timing at a 50 MHz system clock
  localparam int INHIBIT_CYCLES_DEF = 5000;    // 100 us
  localparam int START_TIMEOUT_DEF  = 750000;  // 15 ms
  localparam int PACKET_TIMEOUT_DEF = 100000;  // 2 ms

  // PS/2 device commands
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

  // Odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus falling-edge detect.
// Flops reset high (idle line level) so no edge is reported out of reset.
module ps2_sync_edge (
  input  logic iClk,
  input  logic iResetn,
  input  logic iLine,
  output logic oSync,
  output logic oFall
);

  logic r_meta, r_sync, r_prev;

  // Synchronizer chain and one-cycle history for edge detect
  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= iLine;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign oSync = r_sync;
  assign oFall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data
// bits LSB first, odd parity, stop, then waits for the device ack.
// Optional: define PS2_TX_TIMEOUT_EN to add start/packet timeouts.
module ps2_host_tx
  import fpgart_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int START_TIMEOUT  = START_TIMEOUT_DEF,
  parameter int PACKET_TIMEOUT = PACKET_TIMEOUT_DEF
) (
  input  logic       iClk,
  input  logic       iResetn,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       iPs2Clk,
  input  logic       iPs2Dat,
  output logic       oPs2ClkLow,
  output logic       oPs2DatLow,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  ps2_tx_state_t r_state, w_state_nxt;
  logic [7:0]    r_data,  w_data_nxt;
  logic          r_par,   w_par_nxt;
  logic [3:0]    r_cnt,   w_cnt_nxt;
  logic [31:0]   r_timer, w_timer_nxt;

  logic w_ck_sync, w_ck_fall, w_dat_sync, w_unused_dat_fall;
  logic w_clk_low, w_dat_low, w_done, w_err;

  ps2_sync_edge u_sync_clk (
    .iClk   (iClk),
    .iResetn(iResetn),
    .iLine  (iPs2Clk),
    .oSync  (w_ck_sync),
    .oFall  (w_ck_fall)
  );

  ps2_sync_edge u_sync_dat (
    .iClk   (iClk),
    .iResetn(iResetn),
    .iLine  (iPs2Dat),
    .oSync  (w_dat_sync),
    .oFall  (w_unused_dat_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  logic w_tmo;
`else
  logic w_unused_params;
  assign w_unused_params = ^{32'(START_TIMEOUT), 32'(PACKET_TIMEOUT)};
`endif

  // State and datapath registers
  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_par   <= w_par_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state, datapath updates and line/handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_par_nxt   = r_par;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    w_clk_low   = 1'b0;
    w_dat_low   = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    w_tmo       = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (iSend) begin
          w_data_nxt  = iData;
          w_par_nxt   = odd_parity(iData);
          w_timer_nxt = '0;
          w_state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        w_clk_low   = 1'b1;
        w_timer_nxt = r_timer + 32'd1;
        // Start bit overlaps the last inhibit cycle so data is already
        // low when the clock is released
        if (r_timer == 32'(INHIBIT_CYCLES - 1)) begin
          w_dat_low   = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_dat_low = 1'b1;
        if (w_ck_fall) begin
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_dat_low = ~r_data[r_cnt[2:0]];
        if (w_ck_fall) begin
          if (r_cnt == 4'd7) w_state_nxt = PARITY;
          else               w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      PARITY: begin
        w_dat_low = ~r_par;
        if (w_ck_fall) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_ck_fall) w_state_nxt = ACK;
      end
      ACK: begin
        if (w_ck_fall) begin
          if (!w_dat_sync) begin
            w_state_nxt = WAIT_IDLE;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_ck_sync && w_dat_sync) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Start timer runs from REQ entry; packet timer from the first edge
    if (r_state == REQ) begin
      w_tmo = (r_timer == 32'(START_TIMEOUT));
      if (!w_ck_fall) w_timer_nxt = r_timer + 32'd1;
    end else if (r_state inside {DATA, PARITY, STOP, ACK}) begin
      w_tmo       = (r_timer == 32'(PACKET_TIMEOUT));
      w_timer_nxt = r_timer + 32'd1;
    end
    if (w_tmo) begin
      w_clk_low   = 1'b0;
      w_dat_low   = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b1;
      w_state_nxt = IDLE;
    end
`endif
  end

  assign oPs2ClkLow = w_clk_low;
  assign oPs2DatLow = w_dat_low;
  assign oBusy      = (r_state != IDLE);
  assign oDone      = w_done;
  assign oError     = w_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model,
// table of frames with a scoreboard queue, plus reset/inject/timeout cases.
module tb_ps2_host_tx;
  import fpgart_pkg::*;

  localparam int INH = 40;
  localparam int STO = 300;
  localparam int PTO = 2000;
  localparam int HP  = 20;   // device half period in system cycles

  logic       iClk = 1'b0;
  logic       iResetn = 1'b0;
  logic       iSend = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       iPs2Clk, iPs2Dat;
  logic       oPs2ClkLow, oPs2DatLow, oBusy, oDone, oError;

  assign iPs2Clk = ~(oPs2ClkLow | dev_clk_low);
  assign iPs2Dat = ~(oPs2DatLow | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .PACKET_TIMEOUT(PTO)
  ) dut (
    .iClk      (iClk),
    .iResetn   (iResetn),
    .iData     (iData),
    .iSend     (iSend),
    .iPs2Clk   (iPs2Clk),
    .iPs2Dat   (iPs2Dat),
    .oPs2ClkLow(oPs2ClkLow),
    .oPs2DatLow(oPs2DatLow),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oError    (oError)
  );

  always #10 iClk = ~iClk;

  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_long = 0;
  int run = 0, last_run = 0, n_ovl = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  // Pulse counting and inhibit-length monitor
  always @(negedge iClk) begin
    prev_done <= oDone;
    prev_err  <= oError;
    if (oDone) n_done <= n_done + 1;
    if (oError) n_err <= n_err + 1;
    if (oDone && oError) n_both <= n_both + 1;
    if ((oDone && prev_done) || (oError && prev_err)) n_long <= n_long + 1;
    if (oPs2ClkLow && oPs2DatLow) n_ovl <= n_ovl + 1;
    if (oPs2ClkLow) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge iClk);
    iData = d;
    iSend = 1'b1;
    @(negedge iClk);
    iSend = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks npulse pulses, samples on
  // rising edges. bits[7:0]=data, [8]=parity, [9]=stop, [10]=start.
  task automatic dev_frame(input int npulse, input bit do_ack,
                           output logic [10:0] bits, output bit ok);
    int t = 0;
    bits = '1;
    ok   = 1'b0;
    while (!(iPs2Clk && !iPs2Dat && !oPs2ClkLow) && t < 2000) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 2000) return;
    ok = 1'b1;
    repeat (10) @(negedge iClk);
    for (int p = 1; p <= npulse; p++) begin
      dev_clk_low = 1'b1;
      if (p == 1) bits[10] = iPs2Dat;
      repeat (HP) @(negedge iClk);
      dev_clk_low = 1'b0;
      repeat (2) @(negedge iClk);
      if (p <= 10) bits[p-1] = iPs2Dat;
      if (p == 11 && do_ack) dev_dat_low = 1'b1;
      repeat (HP - 2) @(negedge iClk);
    end
    dev_dat_low = 1'b0;
  endtask

  typedef struct {
    logic [10:0] frame;
    bit          done;
    bit          err;
  } exp_t;
  exp_t sb[$];

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit par, input bit inject);
    exp_t        e;
    logic [10:0] got;
    bit          ok;
    int          d0, e0, t;
    e.frame = {1'b0, 1'b1, par, d};
    e.done  = ack;
    e.err   = !ack;
    sb.push_back(e);
    d0 = n_done;
    e0 = n_err;
    send(d);
    if (inject) begin
      repeat (5) @(negedge iClk);
      send(8'hFF);
    end
    dev_frame(12, ack, got, ok);
    t = 0;
    while (oBusy && t < 100) begin
      @(negedge iClk);
      t++;
    end
    repeat (2) @(negedge iClk);
    e = sb.pop_front();
    chk("req_seen", 32'(ok), 32'd1);
    chk("start_bit", 32'(got[10]), 32'(e.frame[10]));
    chk("data_byte", 32'(got[7:0]), 32'(e.frame[7:0]));
    chk("parity_bit", 32'(got[8]), 32'(e.frame[8]));
    chk("stop_bit", 32'(got[9]), 32'(e.frame[9]));
    chk("done_pulses", 32'(n_done - d0), 32'(e.done));
    chk("error_pulses", 32'(n_err - e0), 32'(e.err));
    chk("busy_after", 32'(oBusy), 32'd0);
    chk("lines_after", 32'({oPs2ClkLow, oPs2DatLow}), 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         ack;
    bit         par;
  } vec_t;

  initial begin
    vec_t        vecs[4];
    logic [10:0] got;
    bit          ok;
    int          d0, e0, c;

    vecs[0] = '{PS2_CMD_ENABLE, 1'b1, 1'b0};
    vecs[1] = '{8'h00,          1'b1, 1'b1};
    vecs[2] = '{PS2_CMD_RESET,  1'b1, 1'b1};
    vecs[3] = '{8'hA5,          1'b0, 1'b1};

    repeat (4) @(negedge iClk);
    chk("reset_outputs", 32'({oPs2ClkLow, oPs2DatLow, oBusy, oDone, oError}), 32'd0);
    iResetn = 1'b1;
    repeat (3) @(negedge iClk);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].d, vecs[i].ack, vecs[i].par, 1'b0);
      if (i == 0) begin
        chk("inhibit_len", 32'(last_run), 32'(INH));
        chk("start_overlap", 32'(n_ovl), 32'd1);
      end
    end

    // Send request during INHIBIT must not replace the latched byte
    run_frame(PS2_CMD_ENABLE, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of data bit 4
    send(PS2_CMD_ENABLE);
    dev_frame(5, 1'b0, got, ok);
    chk("mid_req_seen", 32'(ok), 32'd1);
    d0 = n_done;
    e0 = n_err;
    @(negedge iClk);
    iResetn = 1'b0;
    @(negedge iClk);
    chk("mid_reset_outs", 32'({oPs2ClkLow, oPs2DatLow, oBusy}), 32'd0);
    iResetn = 1'b1;
    repeat (20) @(negedge iClk);
    chk("mid_reset_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    run_frame(PS2_CMD_ENABLE, 1'b1, 1'b0, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: error exactly START_TIMEOUT cycles after REQ entry
    send(8'h12);
    c = 0;
    while (!oPs2ClkLow && c < 200) begin @(negedge iClk); c++; end
    c = 0;
    while (oPs2ClkLow && c < 200) begin @(negedge iClk); c++; end
    chk("inhibit_ended", 32'(oPs2ClkLow), 32'd0);
    e0 = n_err;
    c  = 0;
    while (!oError && c < STO + 50) begin @(negedge iClk); c++; end
    chk("timeout_cycles", 32'(c), 32'(STO));
    chk("timeout_lines", 32'({oPs2ClkLow, oPs2DatLow, oDone}), 32'd0);
    @(negedge iClk);
    chk("timeout_busy", 32'(oBusy), 32'd0);
    chk("timeout_err_cnt", 32'(n_err - e0), 32'd1);
`else
    // Silent device: no timer, the block keeps waiting in REQ
    e0 = n_err;
    send(8'h12);
    repeat (2 * STO) @(negedge iClk);
    chk("no_timeout_busy", 32'(oBusy), 32'd1);
    chk("no_timeout_dat", 32'(oPs2DatLow), 32'd1);
    chk("no_timeout_err", 32'(n_err - e0), 32'd0);
    iResetn = 1'b0;
    @(negedge iClk);
    iResetn = 1'b1;
    @(negedge iClk);
    chk("recover_busy", 32'(oBusy), 32'd0);
`endif

    repeat (5) @(negedge iClk);
    chk("done_err_overlap", 32'(n_both), 32'd0);
    chk("pulse_width", 32'(n_long), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, 5000, iClk cycles PS2_CLK is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, 750000, cycles allowed from clock release to the first device falling edge (15 ms).
REQ-003 SHALL have parameter PACKET_TIMEOUT, 100000, cycles allowed from the first device falling edge to the ack (2 ms).
REQ-004 iClk  in  1  system clock (CLOCK_50); the block has one clock; reset is synchronous and active-low.
REQ-005 iResetn  in  1  synchronous active-low reset.
REQ-006 iData  in  8  command byte, sampled when iSend is accepted.
REQ-007 iSend  in  1  single-cycle send request.
REQ-008 iPs2Clk  in  1  raw PS2_CLK line level.
REQ-009 iPs2Dat  in  1  raw PS2_DAT line level.
REQ-010 oPs2ClkLow  out  1  when 1 the top level drives PS2_CLK to 0, otherwise high-Z.
REQ-011 oPs2DatLow  out  1  when 1 the top level drives PS2_DAT to 0, otherwise high-Z.
REQ-012 oBusy  out  1  high in every state except IDLE.
REQ-013 oDone  out  1  one-cycle pulse on a successful ack.
REQ-014 oError  out  1  one-cycle pulse on a missing ack or a timeout.

Function
REQ-015 SHALL pass iPs2Clk and iPs2Dat through 2-flop synchronizers; a falling edge is synchronized clock 1 in the previous cycle and 0 in the current cycle.
REQ-016 SHALL use states IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-017 IDLE: accept iSend only here, latch iData, compute the odd-parity bit (~^iData), go to INHIBIT; iSend in any other state SHALL be ignored.
REQ-018 INHIBIT: oPs2ClkLow=1 for exactly INHIBIT_CYCLES cycles; on the final cycle assert oPs2DatLow=1 (start bit), then release the clock and enter REQ.
REQ-019 REQ: hold data low; on the first falling edge, drive bit0 (oPs2DatLow = ~bit) and enter DATA.
REQ-020 DATA: on each falling edge, advance to the next bit, LSB first; after the falling edge that ends bit7, drive parity and enter PARITY.
REQ-021 PARITY: on a falling edge, release data (stop bit = 1) and enter STOP.
REQ-022 STOP: on a falling edge enter ACK.
REQ-023 ACK: sample the synchronized data at the next falling edge; 0 SHALL enter WAIT_IDLE; 1 SHALL pulse oError and return to IDLE.
REQ-024 WAIT_IDLE: when the synchronized clock and data are both 1, pulse oDone and return to IDLE in the same cycle.
REQ-025 The outputs oDone and oError SHALL never both be high; each SHALL last exactly one cycle.
REQ-026 On any exit to IDLE, oPs2ClkLow and oPs2DatLow SHALL be 0 in that cycle.
REQ-027 The bit counter SHALL be 4 bits and SHALL reset to 0 on entry to DATA.

Reset
REQ-028 When iResetn=0 at a clock edge, the block SHALL enter IDLE with all outputs at 0, counters cleared and the data register cleared.
REQ-029 Reset mid-transfer SHALL release both lines on the next edge, with no oDone or oError pulse.

Configuration
REQ-030 With PS2_TX_TIMEOUT_EN defined: a timer SHALL run in REQ (limit START_TIMEOUT) and in DATA through ACK (limit PACKET_TIMEOUT, counted from the first edge); on expiry the block SHALL pulse oError, release both lines and go to IDLE.
REQ-031 Without PS2_TX_TIMEOUT_EN: there SHALL be no timers, so the block waits indefinitely, and oError arises only from a missing ack.

Structure
REQ-032 Package fpgart_pkg SHALL hold the state enum, the default timing constants and the PS/2 command constants (0xF4 enable, 0xFF reset).
REQ-033 A sub-module ps2_sync_edge (2-flop sync plus falling-edge detect) SHALL be instantiated twice.

Verification
REQ-034 Send 0xF4 with a device model clocking at 12.5 kHz and acking -> sampled bits 0,0,0,1,0,1,1,1,1, parity 0, stop 1; one oDone pulse; oBusy falls.
REQ-035 Send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; both end with oDone.
REQ-036 The device leaves data high in the ack slot -> one oError pulse, no oDone, both lines released.
REQ-037 PS2_TX_TIMEOUT_EN defined, device never clocks -> oError exactly START_TIMEOUT cycles after REQ entry.
REQ-038 iResetn=0 during DATA bit 4 -> next cycle oPs2ClkLow=0, oPs2DatLow=0, oBusy=0; a following send of 0xF4 succeeds.
REQ-039 iSend pulsed during INHIBIT with iData=0xFF -> ignored; the transmitted byte remains the first byte.
